// File: rtl/tug_referee.sv
// Tug-of-war referee: turns player/computer press pulses into rope movement,
// detects round wins, keeps scores and sequences rounds until the match ends.
module tug_referee #(
  parameter int N_LIGHTS     = 9,
  parameter int SCORE_W      = 3,
  parameter int MATCH_POINTS = 7,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p_press,
  input  logic                c_press,
  output logic [N_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]  p_score,
  output logic [SCORE_W-1:0]  c_score,
  output logic [1:0]          winner,
  output logic                match_over
);

  localparam int POS_W  = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [POS_W-1:0]   POS_C     = POS_W'(N_LIGHTS / 2);
  localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(N_LIGHTS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] MATCH_PTS = SCORE_W'(MATCH_POINTS);

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_COMP   = 2'b10;

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SCORE_W-1:0]  p_score_q, p_score_d;
  logic [SCORE_W-1:0]  c_score_q, c_score_d;
  logic [1:0]          winner_q, winner_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic                match_over_q, match_over_d;

  logic p_only, c_only;

  assign p_only = p_press & ~c_press;
  assign c_only = c_press & ~p_press;

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    hold_d       = hold_q;
    p_score_d    = p_score_q;
    c_score_d    = c_score_q;
    winner_d     = winner_q;

    unique case (state_q)
      S_PLAY: begin
        // Pulling off an end index wins the round; simultaneous pulls cancel.
        if (p_only) begin
          if (pos_q == '0) begin
            state_d  = S_HOLD;
            hold_d   = '0;
            winner_d = WIN_PLAYER;
            if (p_score_q != SCORE_MAX) p_score_d = p_score_q + 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end else if (c_only) begin
          if (pos_q == POS_MAX) begin
            state_d  = S_HOLD;
            hold_d   = '0;
            winner_d = WIN_COMP;
            if (c_score_q != SCORE_MAX) c_score_d = c_score_q + 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (p_score_q == MATCH_PTS || c_score_q == MATCH_PTS) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_PLAY;
            pos_d    = POS_C;
            winner_d = WIN_NONE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_PLAY;
        pos_d   = POS_C;
      end
    endcase

    // Output registers are loaded from next-state so lights track pos with no extra lag.
    lights_d     = '0;
    if (state_d == S_PLAY) lights_d = N_LIGHTS'(1) << pos_d;
    match_over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_PLAY;
      pos_q        <= POS_C;
      hold_q       <= '0;
      p_score_q    <= '0;
      c_score_q    <= '0;
      winner_q     <= WIN_NONE;
      lights_q     <= N_LIGHTS'(1) << POS_C;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      hold_q       <= hold_d;
      p_score_q    <= p_score_d;
      c_score_q    <= c_score_d;
      winner_q     <= winner_d;
      lights_q     <= lights_d;
      match_over_q <= match_over_d;
    end
  end

  assign lights     = lights_q;
  assign p_score    = p_score_q;
  assign c_score    = c_score_q;
  assign winner     = winner_q;
  assign match_over = match_over_q;

endmodule

// File: doc/tug_referee.md
Name: tug_referee

Overview:
- Game controller for the player-vs-computer tug-of-war.
- Takes one-cycle press pulses from the player key conditioner and the computer opponent, and arbitrates them into rope movement.
- Drives the one-hot light bar, detects round wins, keeps per-side scores and sequences rounds up to match end.
- Sits between the key conditioners and the LED/HEX display drivers.

Parameters:
- N_LIGHTS, 9, number of rope lights; must be odd; centre index C = N_LIGHTS/2 (4 by default).
- SCORE_W, 3, width of each score counter.
- MATCH_POINTS, 7, score that ends the match; must be ≤ 2^SCORE_W-1.
- HOLD_CYCLES, 4, cycles the round-win indication is held before the rope re-centres.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- p_press  in  1  player pull; one-cycle pulse from the key conditioner; pulls toward index 0.
- c_press  in  1  computer pull; one-cycle pulse; pulls toward index N_LIGHTS-1.
- lights  out  N_LIGHTS  one-hot rope position; all zero outside PLAY.
- p_score  out  SCORE_W  player rounds won.
- c_score  out  SCORE_W  computer rounds won.
- winner  out  2  00 none, 01 player, 10 computer; valid in HOLD and DONE.
- match_over  out  1  high in DONE.

Behaviour:
- Reset is asynchronous and active-high, and takes effect immediately in any state, including mid-hold.
- On reset: state=PLAY, pos=C, lights=one-hot(C), p_score=0, c_score=0, winner=00, match_over=0, hold counter=0.
- All outputs are registered. lights reflects pos one cycle after the press is sampled.
- PLAY, move arbitration per cycle:
  - p_press only: pos-1.
  - c_press only: pos+1.
  - Both in the same cycle: cancel, no move.
  - Neither: hold.
- PLAY, round win:
  - p_press only with pos==0 → winner=01, p_score+1, enter HOLD.
  - c_press only with pos==N_LIGHTS-1 → winner=10, c_score+1, enter HOLD.
  - pos never wraps; reaching an end index is not itself a win, only a further pull off the end.
- HOLD:
  - lights=0, winner held, both presses ignored.
  - Counter runs 0..HOLD_CYCLES-1, so HOLD lasts exactly HOLD_CYCLES cycles.
  - On exit, if either score == MATCH_POINTS, go to DONE.
  - Otherwise go to PLAY with pos=C and winner=00.
- DONE:
  - lights=0, match_over=1, winner and scores frozen, presses ignored.
  - Leaves only via reset.
- Scores saturate at 2^SCORE_W-1. Under the MATCH_POINTS constraint this is a safety rule only.
- Presses arriving in the same cycle as a state exit are not counted; the first counted press is one cycle into PLAY.

Test Plan (defaults unless stated):
1. Assert reset 5 cycles, then release → lights=9'b000010000, scores 0/0, winner=00, match_over=0.
2. Four p_press pulses then one more → lights walks 4→0. After the fifth pulse: winner=01, p_score=1, lights=0 for exactly 4 cycles, then lights=9'b000010000 and winner=00.
3. c_press twice, then p_press and c_press asserted in the same cycle → pos goes 4→6, then stays 6.
4. After a computer round win, pulse p_press and c_press during HOLD → pos returns to 4; scores unchanged apart from the win; no movement from the ignored presses.
5. With MATCH_POINTS=2, the computer wins two rounds → after the second hold: match_over=1, winner=10, c_score=2. Further presses have no effect; reset clears everything to the initial state.
6. Assert reset asynchronously midway through HOLD (between clock edges) → outputs reach reset values before the next clk edge; scores=0.
